// File: rtl/controlador_transpor_if.sv
// Element streams of the transpose controller: input load stream and result drain stream.
// master = environment (source/sink), slave = controller.
interface controlador_transpor_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/controlador_transpor.sv
// Load/transpose/drain controller: gathers an NxN byte matrix, hands it to an external
// transpose datapath of latency LAT, captures the result and streams it out row-major.
module controlador_transpor #(
   parameter int unsigned N   = 3,
   parameter int unsigned LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   controlador_transpor_if.slave bus,
   output logic [N*N*8-1:0]      mat_to_dp,
   input  logic [N*N*8-1:0]      dp_result,
   output logic                  busy,
   output logic                  done
);
   localparam int unsigned NE = N * N;
   localparam int unsigned KW = $clog2(NE);
   localparam int unsigned LW = $clog2(LAT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      EXEC  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic [KW-1:0] k, k_nx;
   logic [LW-1:0] lat_cnt, lat_nx;
   logic          done_nx;
   logic          capture;
   logic          in_xfer, out_xfer, last_k;
   logic [7:0]    opbuf  [NE];
   logic [7:0]    resbuf [NE];

   // Handshake outputs drop combinationally with abort so no transfer is counted that cycle.
   assign bus.in_ready  = (state == LOAD) && !abort;
   assign bus.out_valid = (state == DRAIN) && !abort;
   assign bus.out_data  = bus.out_valid ? resbuf[k] : '0;

   assign in_xfer  = bus.in_valid && bus.in_ready;
   assign out_xfer = bus.out_valid && bus.out_ready;
   assign last_k   = (k == KW'(NE - 1));
   assign busy     = (state != IDLE);

   always_comb begin
      for (int unsigned i = 0; i < NE; i++) begin
         mat_to_dp[i*8 +: 8] = opbuf[i];
      end
   end

   always_comb begin
      state_nx = state;
      k_nx     = k;
      lat_nx   = lat_cnt;
      done_nx  = 1'b0;
      capture  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nx = LOAD;
               k_nx     = '0;
            end
         end
         LOAD: begin
            if (abort) begin
               state_nx = IDLE;
               k_nx     = '0;
               lat_nx   = '0;
            end else if (in_xfer) begin
               if (last_k) begin
                  state_nx = EXEC;
                  k_nx     = '0;
                  lat_nx   = '0;
               end else begin
                  k_nx = k + 1'b1;
               end
            end
         end
         EXEC: begin
            if (abort) begin
               state_nx = IDLE;
               k_nx     = '0;
               lat_nx   = '0;
            end else if (lat_cnt == LW'(LAT)) begin
               state_nx = DRAIN;
               capture  = 1'b1;
               k_nx     = '0;
               lat_nx   = '0;
            end else begin
               lat_nx = lat_cnt + 1'b1;
            end
         end
         DRAIN: begin
            if (abort) begin
               state_nx = IDLE;
               k_nx     = '0;
               lat_nx   = '0;
            end else if (out_xfer) begin
               if (last_k) begin
                  state_nx = IDLE;
                  k_nx     = '0;
                  done_nx  = 1'b1;
               end else begin
                  k_nx = k + 1'b1;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            k_nx     = '0;
            lat_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         k       <= '0;
         lat_cnt <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         k       <= k_nx;
         lat_cnt <= lat_nx;
         done    <= done_nx;
      end
   end

   // Buffers keep their contents across abort; only reset clears them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NE; i++) begin
            opbuf[i]  <= '0;
            resbuf[i] <= '0;
         end
      end else begin
         if (in_xfer) begin
            opbuf[k] <= bus.in_data;
         end
         if (capture) begin
            for (int unsigned i = 0; i < NE; i++) begin
               resbuf[i] <= dp_result[i*8 +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_controlador_transpor.sv
// Bench for controlador_transpor: LAT=1 and LAT=3 instances, external transpose pipeline model,
// table-driven cycle vectors, directed abort/reset sequences and randomized checked operations.
module tb_controlador_transpor;
   localparam int N    = 3;
   localparam int NE   = N * N;
   localparam int W    = NE * 8;
   localparam int LATA = 1;
   localparam int LATB = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, abort, sel;
   logic       in_valid, out_ready;
   logic [7:0] in_data;

   controlador_transpor_if ifa ();
   controlador_transpor_if ifb ();
   assign ifa.in_valid  = in_valid;
   assign ifa.in_data   = in_data;
   assign ifa.out_ready = out_ready;
   assign ifb.in_valid  = in_valid;
   assign ifb.in_data   = in_data;
   assign ifb.out_ready = out_ready;

   logic start_a, start_b, abort_a, abort_b;
   assign start_a = start & ~sel;
   assign start_b = start & sel;
   assign abort_a = abort & ~sel;
   assign abort_b = abort & sel;

   logic [W-1:0] mat_a, mat_b, dp_a, dp_b;
   logic         busy_a, busy_b, done_a, done_b;

   controlador_transpor #(.N(N), .LAT(LATA)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .bus(ifa.slave),
      .mat_to_dp(mat_a), .dp_result(dp_a), .busy(busy_a), .done(done_a));

   controlador_transpor #(.N(N), .LAT(LATB)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .bus(ifb.slave),
      .mat_to_dp(mat_b), .dp_result(dp_b), .busy(busy_b), .done(done_b));

   function automatic logic [W-1:0] tr(input logic [W-1:0] m);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            r[(i*N+j)*8 +: 8] = m[(j*N+i)*8 +: 8];
      return r;
   endfunction

   // Transpose datapath: LAT-stage pipeline, so the result is only correct LAT edges after the operand settles.
   logic [W-1:0] pa [LATA];
   logic [W-1:0] pb [LATB];
   always @(posedge clk) begin
      pa[0] <= tr(mat_a);
      for (int i = 1; i < LATA; i++) pa[i] <= pa[i-1];
      pb[0] <= tr(mat_b);
      for (int i = 1; i < LATB; i++) pb[i] <= pb[i-1];
   end
   assign dp_a = pa[LATA-1];
   assign dp_b = pb[LATB-1];

   logic         cur_ir, cur_ov, cur_busy, cur_done;
   logic [7:0]   cur_od;
   logic [W-1:0] cur_mat;
   assign cur_ir   = sel ? ifb.in_ready  : ifa.in_ready;
   assign cur_ov   = sel ? ifb.out_valid : ifa.out_valid;
   assign cur_od   = sel ? ifb.out_data  : ifa.out_data;
   assign cur_busy = sel ? busy_b : busy_a;
   assign cur_done = sel ? done_b : done_a;
   assign cur_mat  = sel ? mat_b  : mat_a;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      checks++;
      errors++;
      $display("FAIL %s: no DUT response within cycle budget", name);
   endtask

   typedef struct {
      bit         st, ab, iv;
      logic [7:0] id;
      bit         ordy;
      bit         ir, ov;
      logic [7:0] od;
      bit         bz, dn;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit st, bit ab, bit iv, logic [7:0] id, bit ordy,
                               bit ir, bit ov, logic [7:0] od, bit bz, bit dn);
      vec_t v;
      v.st = st; v.ab = ab; v.iv = iv; v.id = id; v.ordy = ordy;
      v.ir = ir; v.ov = ov; v.od = od; v.bz = bz; v.dn = dn;
      return v;
   endfunction

   // One full operation on the selected instance, judged against a transposition of the loaded data.
   task automatic run_op(input int stall, input bit noise, input bit skip_start, input bit b2b);
      logic [7:0]   d [NE];
      logic [7:0]   e [NE];
      logic [W-1:0] pk;
      int           idx, j, cyc, lat_exp;
      lat_exp = sel ? LATB : LATA;
      for (int i = 0; i < NE; i++) begin
         d[i] = 8'($urandom);
         pk[i*8 +: 8] = d[i];
      end
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            e[r*N+c] = d[c*N+r];
      if (!skip_start) begin
         @(negedge clk);
         start = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
         #1 chk("start_idle_busy", W'(cur_busy), '0);
         @(posedge clk);
      end
      idx = 0; cyc = 0;
      while (idx < NE) begin
         @(negedge clk);
         start    = noise ? 1'($urandom) : 1'b0;
         in_valid = ($urandom_range(99) >= 32'(stall));
         in_data  = in_valid ? d[idx] : 8'($urandom);
         #1;
         chk("load_ready", W'(cur_ir), W'(1));
         chk("load_busy", W'(cur_busy), W'(1));
         if (in_valid) idx++;
         cyc++;
         if (cyc > 500) begin tmo("load"); break; end
         @(posedge clk);
      end
      cyc = 0;
      forever begin
         @(negedge clk);
         start     = noise ? 1'($urandom) : 1'b0;
         in_valid  = 1'($urandom);
         out_ready = ($urandom_range(99) >= 32'(stall));
         #1;
         if (cur_ov) break;
         chk("exec_ready", W'(cur_ir), '0);
         chk("exec_mat", cur_mat, pk);
         cyc++;
         if (cyc > 20) begin tmo("exec"); break; end
         @(posedge clk);
      end
      chk("exec_len", W'(cyc), W'(lat_exp + 1));
      j = 0; cyc = 0;
      forever begin
         chk("drain_valid", W'(cur_ov), W'(1));
         chk("drain_data", W'(cur_od), W'(e[j]));
         chk("drain_done", W'(cur_done), '0);
         if (out_ready) j++;
         @(posedge clk);
         if (j == NE) break;
         cyc++;
         if (cyc > 500) begin tmo("drain"); break; end
         @(negedge clk);
         start     = noise ? 1'($urandom) : 1'b0;
         in_valid  = 1'($urandom);
         out_ready = ($urandom_range(99) >= 32'(stall));
         #1;
      end
      @(negedge clk);
      start = b2b; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("done_pulse", W'(cur_done), W'(1));
      chk("done_busy", W'(cur_busy), '0);
      chk("done_ov", W'(cur_ov), '0);
      chk("done_od", W'(cur_od), '0);
      @(posedge clk);
      if (!b2b) begin
         @(negedge clk);
         start = 1'b0;
         #1 chk("done_once", W'(cur_done), '0);
         @(posedge clk);
      end
   endtask

   // Start and load 1+base..9+base back to back, then wait for the first drain cycle.
   task automatic load_fixed(input logic [7:0] base);
      int cyc;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int i = 0; i < NE; i++) begin
         @(negedge clk);
         start = 1'b0; in_valid = 1'b1; in_data = 8'(i + 1) + base;
         #1 chk("lf_ready", W'(cur_ir), W'(1));
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      #1;
      while (!cur_ov) begin
         cyc++;
         if (cyc > 20) begin tmo("lf_wait"); break; end
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] od;
      rst = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ir_a", W'(ifa.in_ready), '0);
      chk("rst_ov_a", W'(ifa.out_valid), '0);
      chk("rst_od_a", W'(ifa.out_data), '0);
      chk("rst_busy_a", W'(busy_a), '0);
      chk("rst_done_a", W'(done_a), '0);
      chk("rst_mat_a", mat_a, '0);
      chk("rst_busy_b", W'(busy_b), '0);
      chk("rst_mat_b", mat_b, '0);
      rst = 1'b1;

      // Cycle table: plain 1..9 operation with a start pulse ignored mid-load.
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < NE; i++)
         tbl.push_back(mk((i == 3), 0, 1, 8'(i + 1), 0, 1, 0, 0, 1, 0));
      for (int i = 0; i < LATA + 1; i++)
         tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
      for (int i = 0; i < NE; i++) begin
         od = 8'((i % N) * N + i / N + 1);
         tbl.push_back(mk((i == 4), 0, 0, 0, 1, 0, 1, od, 1, 0));
      end
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         start = tbl[i].st; abort = tbl[i].ab; in_valid = tbl[i].iv;
         in_data = tbl[i].id; out_ready = tbl[i].ordy;
         #1;
         chk($sformatf("tbl%0d_ir", i), W'(cur_ir), W'(tbl[i].ir));
         chk($sformatf("tbl%0d_ov", i), W'(cur_ov), W'(tbl[i].ov));
         chk($sformatf("tbl%0d_od", i), W'(cur_od), W'(tbl[i].od));
         chk($sformatf("tbl%0d_busy", i), W'(cur_busy), W'(tbl[i].bz));
         chk($sformatf("tbl%0d_done", i), W'(cur_done), W'(tbl[i].dn));
         @(posedge clk);
      end

      // start and abort together in IDLE: abort wins.
      @(negedge clk);
      start = 1'b1; abort = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      #1 chk("sa_idle_busy", W'(cur_busy), '0);
      chk("sa_idle_ir", W'(cur_ir), '0);

      // Abort after four loaded elements.
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b0; in_valid = 1'b1; in_data = 8'(8'hA0 + i);
         #1 chk("ab_load_ready", W'(cur_ir), W'(1));
         @(posedge clk);
      end
      @(negedge clk);
      abort = 1'b1; in_valid = 1'b1;
      #1 chk("ab_ready_low", W'(cur_ir), '0);
      chk("ab_busy_still", W'(cur_busy), W'(1));
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0; in_valid = 1'b0;
      #1 chk("ab_idle_busy", W'(cur_busy), '0);
      chk("ab_no_done", W'(cur_done), '0);
      @(posedge clk);
      run_op(0, 0, 0, 0);

      // Abort in DRAIN after two transfers.
      load_fixed(8'h10);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      #1 chk("abd_ov", W'(cur_ov), '0);
      chk("abd_od", W'(cur_od), '0);
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0; out_ready = 1'b0;
      #1 chk("abd_busy", W'(cur_busy), '0);
      chk("abd_done", W'(cur_done), '0);
      @(posedge clk);
      @(negedge clk);
      #1 chk("abd_done_later", W'(cur_done), '0);

      // Reset during DRAIN with k = 5.
      load_fixed(8'h20);
      out_ready = 1'b1;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
      end
      #1 chk("pre_rst_od", W'(cur_od), W'(8'h28));
      rst = 1'b0;
      #1;
      chk("mrst_ir", W'(cur_ir), '0);
      chk("mrst_ov", W'(cur_ov), '0);
      chk("mrst_od", W'(cur_od), '0);
      chk("mrst_busy", W'(cur_busy), '0);
      chk("mrst_done", W'(cur_done), '0);
      chk("mrst_mat", cur_mat, '0);
      @(negedge clk);
      rst = 1'b1; out_ready = 1'b0;
      run_op(0, 0, 0, 0);

      // Randomized operations on LAT=1, alternating back-to-back starts in the done cycle.
      for (int i = 0; i < 6; i++)
         run_op(int'($urandom_range(60)), 1'b1, (i % 2) == 1, (i % 2) == 0);

      // LAT=3 instance.
      @(negedge clk);
      sel = 1'b1;
      run_op(0, 0, 0, 0);
      run_op(40, 1, 0, 1);
      run_op(25, 1, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
